fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 3-stage RV32I pipeline; sits directly upstream of the decode/register-read stage.
- Owns the fetch PC, issues word requests to the instruction cache and absorbs variable cache latency.
- Hands decode one instruction plus its PC per cycle, or a bubble when none is available.
- Honours decode back-pressure (stall) and execute-stage redirects (taken branch/jump).

Parameters:
RESET_PC, 32'h0000_2000, first fetch address after reset
ADDR_W, 32, PC/address width

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
icache_addr  output  32  word-aligned request address
icache_req  output  1  request strobe
icache_ready  input  1  cache accepts request this cycle (accept = icache_req & icache_ready)
icache_valid  input  1  response data valid this cycle
icache_dout  input  32  response instruction word
stall  input  1  decode cannot accept; hold outputs
redirect  input  1  execute resolved taken branch/jump
redirect_pc  input  32  redirect target
instr  output  32  instruction to decode
instr_pc  output  32  PC of instr
bubble  output  1  1 = instr/instr_pc invalid; decode inserts NOP

Behaviour:
- Reset: asynchronous on rst_n low. pc_fetch=RESET_PC, state=ISSUE, skid empty, drop=0, bubble=1, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, icache_req=0 while rst_n low.
- Maximum one outstanding request. Cache responses are in order and arrive no earlier than the cycle after acceptance.
- FSM:
  - ISSUE: icache_req=1 and icache_addr=pc_fetch, only if the skid is empty. On accept: pc_req<=pc_fetch, pc_fetch<=pc_fetch+4, go to WAIT.
  - WAIT: icache_req=0. On icache_valid: deliver the response (below), go to ISSUE.
  - DROP: entered from WAIT on redirect. icache_req=0. On icache_valid: discard the response, go to ISSUE.
- Delivery of a response (pc_req, icache_dout):
  - stall=0 and skid empty: registered to instr/instr_pc with bubble=0 next cycle.
  - otherwise: written to the one-entry skid (skid_instr, skid_pc, skid_v=1).
- Output register, updated when stall=0 (one-cycle latency, response to decode):
  - skid_v: load skid, clear skid_v, bubble=0.
  - else response delivered this cycle: load it, bubble=0.
  - else: bubble=1.
- When stall=1: instr, instr_pc and bubble hold. Responses go to the skid only. A second response cannot occur while the skid is full because ISSUE is blocked.
- Redirect (highest priority, independent of stall):
  - pc_fetch<=redirect_pc with bits [1:0] forced to 0.
  - skid_v<=0; bubble<=1 next cycle; any response arriving the same cycle is discarded.
  - State goes to DROP if a request is outstanding and its response has not arrived this cycle, else ISSUE.
  - A request presented in the redirect cycle is suppressed (icache_req=0).
- Simultaneous icache_valid and redirect in WAIT: response discarded, state goes to ISSUE.
- Redirect while already in DROP: pc_fetch updated, remains in DROP.
- pc_fetch+4 wraps modulo 2^32 with no flag.
- rst_n assertion mid-request: all state cleared immediately. The cache is responsible for squashing its own in-flight response. Any icache_valid in the first post-reset cycle is ignored (drop=1 for that cycle).

Decomposition:
- Shared package/header: RESET_PC default, NOP encoding 32'h0000_0013, fetch FSM state encodings (ISSUE, WAIT, DROP).
- Opcode constants stay in the existing opcode header.
- One natural sub-module: fetch_skid_buffer, holding the one-entry {instr, pc} holding register with valid, load and clear.
- FSM and PC logic remain in fetch_stage.

Test Plan:
- Reset then zero-latency-plus-one cache, stall=0: requests 0x2000, 0x2004, 0x2008. Decode sees bubble=1 then instr_pc 0x2000 two cycles after the first accept; thereafter alternating bubble/valid (one outstanding limit).
- Response for 0x2004 arrives with stall=1 for 3 cycles: outputs hold 0x2000; skid holds 0x2004 and no new request issues. Stall drops: 0x2004 presented next cycle, then a request for 0x2008 issues.
- Redirect to 0x3002 while 0x2008 is outstanding with a 4-cycle miss: the 0x2008 response is discarded; next request address is 0x3000; bubble=1 until the 0x3000 response.
- Redirect in the same cycle as icache_valid, and also with stall=1 and skid full: skid cleared, bubble=1 next cycle, next fetch at the redirect target.
- rst_n pulsed low for 1 cycle mid-WAIT: outputs immediately return to reset values; the first post-reset request is 0x2000.
- icache_ready held low for 5 cycles: icache_req and icache_addr stay stable at 0x2000; the single accept occurs on the cycle ready rises.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_2000;
    localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched {instr, pc} pair that decode could not take.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc;

    // Load wins over clear; the parent never asks for both in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= FETCH_NOP;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one i-cache request in flight,
// and hands decode one instruction per cycle or a bubble, honouring stall and redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] icache_addr,
    output logic              icache_req,
    input  logic              icache_ready,
    input  logic              icache_valid,
    input  logic [31:0]       icache_dout,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              bubble
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc_fetch;
    logic [ADDR_W-1:0] w_pc_fetch_next;
    logic [ADDR_W-1:0] r_pc_req;
    logic              r_drop;

    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_bubble;

    logic              w_skid_v;
    logic [31:0]       w_skid_instr;
    logic [ADDR_W-1:0] w_skid_pc;
    logic              w_skid_load;
    logic              w_skid_clear;

    logic              w_accept;
    logic              w_resp_in;
    logic              w_deliver;
    logic              w_outstanding;

    // A full skid blocks new requests, which guarantees it can never overflow.
    always_comb begin
        icache_addr   = r_pc_fetch;
        icache_req    = rst_n && (r_state == ST_ISSUE) && !w_skid_v && !redirect;
        w_accept      = icache_req && icache_ready;
        w_resp_in     = icache_valid && !r_drop;
        w_outstanding = (r_state == ST_WAIT) || (r_state == ST_DROP);
        w_deliver     = w_resp_in && (r_state == ST_WAIT) && !redirect;
        w_skid_load   = w_deliver && (stall || w_skid_v);
        w_skid_clear  = redirect || (!stall && w_skid_v);
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_fetch_next = r_pc_fetch;
        case (r_state)
            ST_ISSUE: begin
                if (w_accept) begin
                    w_state_next    = ST_WAIT;
                    w_pc_fetch_next = r_pc_fetch + ADDR_W'(4);
                end
            end
            ST_WAIT: begin
                if (w_resp_in) w_state_next = ST_ISSUE;
            end
            ST_DROP: begin
                if (w_resp_in) w_state_next = ST_ISSUE;
            end
            default: w_state_next = ST_ISSUE;
        endcase
        // Redirect overrides everything; an in-flight response still owed becomes garbage to drop.
        if (redirect) begin
            w_pc_fetch_next = redirect_pc & ~ADDR_W'(3);
            w_state_next    = (w_outstanding && !w_resp_in) ? ST_DROP : ST_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ISSUE;
            r_pc_fetch <= RESET_PC;
            r_pc_req   <= RESET_PC;
            r_drop     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_pc_fetch <= w_pc_fetch_next;
            r_drop     <= 1'b0;
            if (w_accept) r_pc_req <= r_pc_fetch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= FETCH_NOP;
            r_instr_pc <= RESET_PC;
            r_bubble   <= 1'b1;
        end else if (redirect) begin
            r_bubble <= 1'b1;
        end else if (!stall) begin
            if (w_skid_v) begin
                r_instr    <= w_skid_instr;
                r_instr_pc <= w_skid_pc;
                r_bubble   <= 1'b0;
            end else if (w_deliver) begin
                r_instr    <= icache_dout;
                r_instr_pc <= r_pc_req;
                r_bubble   <= 1'b0;
            end else begin
                r_bubble <= 1'b1;
            end
        end
    end

    fetch_skid_buffer #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (icache_dout),
        .i_pc    (r_pc_req),
        .o_valid (w_skid_v),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    assign instr    = r_instr;
    assign instr_pc = r_instr_pc;
    assign bubble   = r_bubble;

endmodule
